// File: rtl/spi_dac_monitor.sv
// spi_dac_monitor
// Passive sniffer for a nanoDAC-style SPI link (CPOL=1, CPHA=1, MSB first).
// Every frame framed by n_cs is captured, length/format/sequence checked,
// and reported on registered outputs one sys_clk after the synchronized
// n_cs rising edge.
//
// Ports
//   sys_clk    : system clock, at least 4x the sclk rate
//   n_rst      : synchronous active-low reset
//   sclk       : SPI clock from the master (idle high)
//   mosi       : SPI data from the master
//   n_cs       : active-low frame select (DAC n_sync)
//   clr_err    : one-cycle pulse clearing err_sticky
//   out_data   : last complete (WIDTH-bit) frame
//   out_valid  : one-cycle pulse on every out_data update
//   value      : value field [19:4] of the last good frame
//   frame_err  : pulse, frame length differed from WIDTH
//   fmt_err    : pulse, command nibble or trailing zero nibble wrong
//   seq_err    : pulse, value did not follow the previous good value by +1
//   err_sticky : OR of all error pulses since the last clr_err
//   frame_cnt  : saturating count of good frames
//   busy       : high while a frame is being shifted in
module spi_dac_monitor #(
    parameter int         WIDTH = 24,
    parameter logic [3:0] CMD   = 4'b0011
) (
    input  logic             sys_clk,
    input  logic             n_rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             n_cs,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [15:0]      value,
    output logic             frame_err,
    output logic             fmt_err,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [15:0]      frame_cnt,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] WAIT_IDLE = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;

    // Frame format: command nibble on top, four zero bits at the bottom.
    function automatic logic fmt_ok(input logic [WIDTH-1:0] f);
        return (f[23:20] == CMD) && (f[3:0] == 4'b0000);
    endfunction

    logic             sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic             ncs_meta_r, ncs_sync_r, ncs_prev_r;
    logic             mosi_meta_r, mosi_sync_r;
    logic [1:0]       sync_fill_r;
    logic [1:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic             have_ref_r;

    logic sclk_rise_s, ncs_fall_s, ncs_rise_s, sync_primed_s;
    logic frame_done_s, len_ok_s, fmt_ok_s, seq_bad_s, err_now_s;
    logic [15:0] rx_value_s;

    assign sclk_rise_s   = sclk_sync_r & ~sclk_prev_r;
    assign ncs_fall_s    = ~ncs_sync_r & ncs_prev_r;
    assign ncs_rise_s    = ncs_sync_r & ~ncs_prev_r;
    // The synchronizers hold forced idle levels for two cycles after reset;
    // only trust n_cs=1 once the real pin level has propagated through, so a
    // frame still in progress at reset release is not mistaken for idle.
    assign sync_primed_s = sync_fill_r[1];

    assign frame_done_s = (state_r == SHIFT) && ncs_rise_s;
    assign len_ok_s     = (bit_cnt_r == CNT_FULL);
    assign fmt_ok_s     = fmt_ok(shift_r);
    assign rx_value_s   = shift_r[19:4];
    assign seq_bad_s    = have_ref_r && (rx_value_s != (value + 16'd1));
    assign err_now_s    = frame_done_s && (!len_ok_s || !fmt_ok_s || seq_bad_s);

    // Two-flop synchronizers plus edge-detect history, reset to idle levels.
    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            sclk_meta_r <= 1'b1;
            sclk_sync_r <= 1'b1;
            sclk_prev_r <= 1'b1;
            ncs_meta_r  <= 1'b1;
            ncs_sync_r  <= 1'b1;
            ncs_prev_r  <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            sync_fill_r <= 2'b00;
        end else begin
            sclk_meta_r <= sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            ncs_meta_r  <= n_cs;
            ncs_sync_r  <= ncs_meta_r;
            ncs_prev_r  <= ncs_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
            sync_fill_r <= {sync_fill_r[0], 1'b1};
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_IDLE: begin
                if (sync_primed_s && ncs_sync_r) state_nxt_s = IDLE;
                else                             state_nxt_s = WAIT_IDLE;
            end
            IDLE: begin
                if (ncs_fall_s) state_nxt_s = SHIFT;
                else            state_nxt_s = IDLE;
            end
            SHIFT: begin
                if (ncs_rise_s) state_nxt_s = IDLE;
                else            state_nxt_s = SHIFT;
            end
            default: state_nxt_s = WAIT_IDLE;
        endcase
    end

    // State, shift register, frame evaluation and registered results.
    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            state_r    <= WAIT_IDLE;
            busy       <= 1'b0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            have_ref_r <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            value      <= 16'h0000;
            frame_cnt  <= 16'h0000;
            frame_err  <= 1'b0;
            fmt_err    <= 1'b0;
            seq_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy      <= (state_nxt_s == SHIFT);
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            fmt_err   <= 1'b0;
            seq_err   <= 1'b0;

            if ((state_r == IDLE) && ncs_fall_s) begin
                bit_cnt_r <= '0;
                shift_r   <= '0;
            end else if ((state_r == SHIFT) && sclk_rise_s) begin
                shift_r <= {shift_r[WIDTH-2:0], mosi_sync_r};
                if (bit_cnt_r != CNT_SAT) bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end

            if (frame_done_s) begin
                if (!len_ok_s) begin
                    frame_err <= 1'b1;
                end else begin
                    out_data  <= shift_r;
                    out_valid <= 1'b1;
                    if (!fmt_ok_s) begin
                        fmt_err <= 1'b1;
                    end else begin
                        // Reference always follows the received value so a
                        // single skip produces exactly one seq_err.
                        value      <= rx_value_s;
                        have_ref_r <= 1'b1;
                        seq_err    <= seq_bad_s;
                        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
                    end
                end
            end

            // Set covers both the evaluation cycle and the visible pulse
            // cycle, so a coincident clr_err can never hide an error.
            if (err_now_s || frame_err || fmt_err || seq_err) err_sticky <= 1'b1;
            else if (clr_err)                                err_sticky <= 1'b0;
        end
    end

endmodule

// File: doc/spi_dac_monitor.md
SPI_DAC_MONITOR -- requirements
Module: spi_dac_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the frame length in bits.
REQ-002 The block SHALL have parameter CMD, default 4'b0011, giving the expected command nibble in frame bits [23:20].
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock, at least 4x the sclk frequency.
REQ-004 The block SHALL have port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port sclk, input, 1 bit: SPI clock from the master, CPOL=1, CPHA=1.
REQ-006 The block SHALL have port mosi, input, 1 bit: SPI data from the master, MSB first.
REQ-007 The block SHALL have port n_cs, input, 1 bit: active-low frame select (nanoDAC n_sync).
REQ-008 The block SHALL have port clr_err, input, 1 bit: a one-cycle pulse that clears err_sticky.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the last complete frame.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking an out_data update.
REQ-011 The block SHALL have port value, output, 16 bits: frame bits [19:4] of the last good frame.
REQ-012 The block SHALL have ports frame_err, fmt_err and seq_err, output, 1 bit each: one-cycle error pulses.
REQ-013 The block SHALL have port err_sticky, output, 1 bit: the OR of all errors since the last clear (drives a red LED).
REQ-014 The block SHALL have port frame_cnt, output, 16 bits: count of good frames, saturating at 0xFFFF.
REQ-015 The block SHALL have port busy, output, 1 bit: high while in state SHIFT.

Function
REQ-016 Each of sclk, mosi and n_cs SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized copies only.
REQ-017 A rising edge of synchronized sclk SHALL shift synchronized mosi into the LSB of the shift register and increment bit_cnt; falling edges SHALL be ignored.
REQ-018 bit_cnt SHALL saturate at WIDTH+1.
REQ-019 FSM states SHALL be WAIT_IDLE, IDLE and SHIFT; the reset state SHALL be WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL go to IDLE on the first cycle synchronized n_cs is high, so a frame already in progress at reset release is discarded.
REQ-021 IDLE SHALL go to SHIFT on a synchronized n_cs falling edge, clearing bit_cnt and the shift register.
REQ-022 SHIFT SHALL go to IDLE on a synchronized n_cs rising edge, and the frame SHALL be evaluated in that same cycle.
REQ-023 All result outputs SHALL be registered and valid one sys_clk after the synchronized n_cs rising edge, i.e. 3 sys_clk after the pin edge.
REQ-024 For a frame with bit_cnt != WIDTH, the block SHALL pulse frame_err and SHALL leave out_data, value, out_valid and frame_cnt unchanged.
REQ-025 For a frame with bit_cnt == WIDTH, the block SHALL update out_data and pulse out_valid, whatever the result of the format check.
REQ-026 A frame with bits[23:20] != CMD or bits[3:0] != 0 SHALL pulse fmt_err and SHALL NOT update value, frame_cnt or the sequence reference.
REQ-027 A frame that is WIDTH bits long and passes the format check is a good frame and SHALL update value and increment frame_cnt.
REQ-028 The first good frame after reset SHALL set the sequence reference with no seq_err.
REQ-029 Each later good frame SHALL pulse seq_err if its value field != (previous value + 1) mod 2^16; 0xFFFF -> 0x0000 SHALL be legal.
REQ-030 The sequence reference SHALL always take the received value, so one skipped value gives exactly one seq_err.
REQ-031 err_sticky SHALL set on any error pulse; if clr_err and an error pulse occur in the same cycle, the set SHALL win.
REQ-032 A synchronized n_cs rising edge seen in IDLE or WAIT_IDLE SHALL produce no output activity.
REQ-033 sclk edges while n_cs is high SHALL be ignored.

Reset
REQ-034 While n_rst is low at a sys_clk edge, out_data, value, frame_cnt, bit_cnt, the shift register and all pulses, err_sticky and busy SHALL go to 0.
REQ-035 While n_rst is low, the synchronizers SHALL load the idle levels sclk=1, n_cs=1, mosi=0, and the FSM SHALL go to WAIT_IDLE.
REQ-036 A reset mid-frame SHALL abort the frame with no error pulse.

Verification
REQ-037 Bench SHALL cover: frames 0x3 0000 0, 0x3 0001 0, 0x3 0002 0 -> three out_valid pulses, value 0x0002, frame_cnt 3, no errors.
REQ-038 Bench SHALL cover: value 0xFFFF then 0x0000 -> no seq_err; then value 0x0005 -> one seq_err, err_sticky=1, value=0x0005.
REQ-039 Bench SHALL cover: 23-bit frame and 25-bit frame -> frame_err each, out_valid=0, frame_cnt unchanged.
REQ-040 Bench SHALL cover: frame 0x2 0010 0 -> out_valid and fmt_err; value and frame_cnt unchanged; the next frame 0x3 0011 0 after previous 0x0010 -> no seq_err.
REQ-041 Bench SHALL cover: n_rst pulsed low after bit 10, and n_cs then held low for the rest of that frame -> no outputs; the next full frame is accepted as the first frame.
REQ-042 Bench SHALL cover: clr_err coincident with a seq_err pulse -> err_sticky=1; a later lone clr_err -> err_sticky=0.
